// File: rtl/stopwatch_display.sv
// Multiplexed 4-digit seven-segment driver for the stopwatch counter: one digit
// per refresh slot, digits sampled once per frame, adjusted pair blinks.
module stopwatch_display #(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 2,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] minutes_top_digit,
  input  logic [3:0] minutes_bot_digit,
  input  logic [3:0] seconds_top_digit,
  input  logic [3:0] seconds_bot_digit,
  input  logic       is_minute_increasing,
  input  logic       is_second_increasing,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0][3:0] digit_q, digit_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_phase_q, blink_phase_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic [3:0]      an_q, an_d;
  logic            slot_end;
  logic            blink_wrap;
  logic            blank;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'h7F;
    endcase
  endfunction

  always_comb begin
    slot_end = (cnt_q == CW'(REFRESH_DIV - 1));
    cnt_d    = slot_end ? '0 : cnt_q + CW'(1);
    idx_d    = slot_end ? idx_q + 2'd1 : idx_q;

    // Latch slot order matches idx: 0 = rightmost digit.
    digit_d = digit_q;
    if (slot_end && (idx_q == 2'd3)) begin
      digit_d[0] = seconds_bot_digit;
      digit_d[1] = seconds_top_digit;
      digit_d[2] = minutes_bot_digit;
      digit_d[3] = minutes_top_digit;
    end

    blink_wrap    = (blink_cnt_q == BW'(BLINK_DIV - 1));
    blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + BW'(1);
    blink_phase_d = blink_wrap ? ~blink_phase_q : blink_phase_q;

    blank = ~blink_phase_q & (idx_q[1] ? is_minute_increasing : is_second_increasing);

    an_d  = 4'hF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if ((cnt_q >= CW'(GUARD)) && !blank) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = decode(digit_q[idx_q]);
      dp_d  = (idx_q != 2'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      digit_q       <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      an_q          <= 4'hF;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      digit_q       <= digit_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// Self-checking bench for stopwatch_display: every cycle is compared against a
// step-count model of the scan, plus a decode table and directed corner cases.
module tb_stopwatch_display;

  localparam int RD = 4;
  localparam int GD = 1;
  localparam int BD = 64;
  localparam int FRAME = 4 * RD;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] minutes_top_digit = '0;
  logic [3:0] minutes_bot_digit = '0;
  logic [3:0] seconds_top_digit = '0;
  logic [3:0] seconds_bot_digit = '0;
  logic       is_minute_increasing = 1'b0;
  logic       is_second_increasing = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int tests = 0;
  int fails = 0;

  // Model state: s = rising edges with rst=1 since the last reset.
  int         s = 0;
  logic [3:0] mlatch [4];

  stopwatch_display #(.REFRESH_DIV(RD), .GUARD(GD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst),
    .minutes_top_digit(minutes_top_digit), .minutes_bot_digit(minutes_bot_digit),
    .seconds_top_digit(seconds_top_digit), .seconds_bot_digit(seconds_bot_digit),
    .is_minute_increasing(is_minute_increasing), .is_second_increasing(is_second_increasing),
    .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] digit;
    logic [6:0] exp_seg;
  } vec_t;
  vec_t vecs [16];

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] t [10];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
          7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return (d < 4'd10) ? t[d] : 7'h7F;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (s=%0d, t=%0t)", name, act, exp, s, $time);
    end
  endtask

  task automatic step();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    bit         chk_sd;
    int         cnt, idx;
    bit         phase, blanked;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; chk_sd = 1'b1;
    if (rst) begin
      cnt     = s % RD;
      idx     = (s / RD) % 4;
      phase   = ((s / BD) % 2) == 0;
      blanked = !phase && ((idx >= 2) ? is_minute_increasing : is_second_increasing);
      if (blanked) begin
        chk_sd = 1'b1;
      end else if (cnt < GD) begin
        chk_sd = 1'b0;
      end else begin
        e_an  = ~(4'b0001 << idx);
        e_seg = seg_of(mlatch[idx]);
        e_dp  = (idx == 2) ? 1'b0 : 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("an", an, e_an);
    if (chk_sd) begin
      chk("seg", seg, e_seg);
      chk("dp", dp, e_dp);
    end
    if (!rst) begin
      s = 0;
      for (int i = 0; i < 4; i++) mlatch[i] = '0;
    end else begin
      if ((s % FRAME) == FRAME - 1) begin
        mlatch[0] = seconds_bot_digit;
        mlatch[1] = seconds_top_digit;
        mlatch[2] = minutes_bot_digit;
        mlatch[3] = minutes_top_digit;
      end
      s++;
    end
  endtask

  // Advance until the next edge will reflect frame position p, bounded by one frame.
  task automatic run_to(input int p);
    for (int k = 0; k < FRAME && (s % FRAME) != p; k++) step();
  endtask

  task automatic run_to_mod(input int m, input int p);
    for (int k = 0; k < m && (s % m) != p; k++) step();
  endtask

  task automatic set_digits(input logic [3:0] mt, input logic [3:0] mb,
                            input logic [3:0] st, input logic [3:0] sb);
    minutes_top_digit = mt; minutes_bot_digit = mb;
    seconds_top_digit = st; seconds_bot_digit = sb;
  endtask

  initial begin
    vecs = '{
      '{4'd0,  7'b1000000}, '{4'd1,  7'b1111001}, '{4'd2,  7'b0100100}, '{4'd3,  7'b0110000},
      '{4'd4,  7'b0011001}, '{4'd5,  7'b0010010}, '{4'd6,  7'b0000010}, '{4'd7,  7'b1111000},
      '{4'd8,  7'b0000000}, '{4'd9,  7'b0010000}, '{4'd10, 7'h7F},      '{4'd11, 7'h7F},
      '{4'd12, 7'h7F},      '{4'd13, 7'h7F},      '{4'd14, 7'h7F},      '{4'd15, 7'h7F}
    };
    for (int i = 0; i < 4; i++) mlatch[i] = '0;

    // Reset held for 3 cycles, inputs nonzero to prove they are ignored.
    set_digits(4'd7, 4'd7, 4'd7, 4'd7);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("reset_an", an, 4'hF);
    chk("reset_seg", seg, 7'h7F);
    rst = 1'b1;
    step();
    chk("first_guard_an", an, 4'hF);
    step();
    chk("first_frame_an", an, 4'hE);
    chk("first_frame_zero", seg, 7'b1000000);

    // Digits 1,2,3,4 over two frames.
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    run_to(FRAME - 1); step();
    run_to(FRAME - 1); step();
    run_to(1);  step(); chk("f2_slot0_an", an, 4'hE); chk("f2_slot0_seg", seg, 7'b0011001);
    run_to(5);  step(); chk("f2_slot1_an", an, 4'hD); chk("f2_slot1_seg", seg, 7'b0110000);
    run_to(8);  step(); chk("f2_slot2_guard", an, 4'hF);
    step();             chk("f2_slot2_an", an, 4'hB); chk("f2_slot2_seg", seg, 7'b0100100);
                        chk("f2_slot2_dp", dp, 0);
    run_to(13); step(); chk("f2_slot3_an", an, 4'h7); chk("f2_slot3_seg", seg, 7'b1111001);

    // Input change mid-frame is deferred to the next frame.
    run_to(4);
    seconds_bot_digit = 4'd9;
    run_to(FRAME - 1); step();
    run_to(1); step(); chk("deferred_9", seg, 7'b0010000);

    // Decode table on the rightmost digit.
    for (int v = 0; v < 16; v++) begin
      seconds_bot_digit = vecs[v].digit;
      run_to(FRAME - 1); step();
      run_to(1); step();
      chk("table_an", an, 4'hE);
      chk("table_seg", seg, vecs[v].exp_seg);
      $display("[TB] vec %0d digit %0d seg %b", v, vecs[v].digit, seg);
    end

    // Invalid code in slot 1 blanks only that digit.
    set_digits(4'd1, 4'd2, 4'hC, 4'd4);
    run_to(FRAME - 1); step();
    run_to(5); step(); chk("hexC_an", an, 4'hD); chk("hexC_seg", seg, 7'h7F);
    run_to(9); step(); chk("hexC_slot2", seg, 7'b0100100);

    // Minutes blink.
    set_digits(4'd5, 4'd9, 4'd5, 4'd9);
    is_minute_increasing = 1'b1;
    run_to(FRAME - 1); step();
    run_to_mod(2 * BD, BD + 13); step();
    chk("blink_min_an", an, 4'hF); chk("blink_min_seg", seg, 7'h7F); chk("blink_min_dp", dp, 1);
    run_to_mod(2 * BD, BD + 17); step();
    chk("blink_sec_an", an, 4'hE); chk("blink_sec_seg", seg, 7'b0010000);
    run_to_mod(2 * BD, 13); step();
    chk("blink_back_an", an, 4'h7); chk("blink_back_seg", seg, 7'b0010010);
    is_minute_increasing = 1'b0;

    // Reset for one cycle in the middle of slot 2.
    run_to(9);
    rst = 1'b0;
    step(); chk("midrst_an", an, 4'hF); chk("midrst_seg", seg, 7'h7F); chk("midrst_dp", dp, 1);
    rst = 1'b1;
    step(); chk("midrst_guard", an, 4'hF);
    step(); chk("midrst_idx0", an, 4'hE); chk("midrst_zero", seg, 7'b1000000);

    // Random digits, flags and occasional resets against the model.
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: minutes_top_digit = 4'($urandom_range(0, 15));
          1: minutes_bot_digit = 4'($urandom_range(0, 15));
          2: seconds_top_digit = 4'($urandom_range(0, 15));
          default: seconds_bot_digit = 4'($urandom_range(0, 15));
        endcase
      end
      if ($urandom_range(0, 39) == 0) is_minute_increasing = ~is_minute_increasing;
      if ($urandom_range(0, 39) == 0) is_second_increasing = ~is_second_increasing;
      rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stopwatch_display.md
Name: stopwatch_display

Overview:
- Consumes the four BCD digit outputs and the two adjust flags of the stopwatch counter.
- Drives a 4-digit common-anode multiplexed seven-segment display.
- Scans one digit per refresh slot and samples the digits once per frame, so a frame never mixes two counts.
- Blanks the digit pair being adjusted with a periodic blink.
- Sits between the counter and the board pins.

Parameters:
- REFRESH_DIV, 50000, clock cycles per digit slot (min 2).
- GUARD, 2, leading cycles of each slot with all anodes off (anti-ghosting); must be < REFRESH_DIV.
- BLINK_DIV, 25000000, clock cycles per blink half-period (min 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low (0 = reset, sampled on rising clk).
- minutes_top_digit  in  4  BCD, leftmost digit.
- minutes_bot_digit  in  4  BCD.
- seconds_top_digit  in  4  BCD.
- seconds_bot_digit  in  4  BCD, rightmost digit.
- is_minute_increasing  in  1  minutes pair is being adjusted (blink).
- is_second_increasing  in  1  seconds pair is being adjusted (blink).
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  4  anode enables, active-low; an[3] is leftmost.

Behaviour:
- Reset (rst=0 at a rising edge):
  - seg=7'h7F, dp=1, an=4'hF.
  - slot counter cnt=0, slot index idx=0.
  - Latched digits all 0.
  - blink counter=0, blink_phase=1 (visible).
  - Reset mid-frame aborts the scan immediately; the next rst=1 cycle restarts at idx=0, cnt=0.
- Slot timing:
  - cnt runs 0..REFRESH_DIV-1.
  - At cnt=REFRESH_DIV-1, cnt wraps to 0 and idx advances 0→1→2→3→0.
- Slot mapping:
  - idx 0 → seconds_bot_digit, an[0].
  - idx 1 → seconds_top_digit, an[1].
  - idx 2 → minutes_bot_digit, an[2].
  - idx 3 → minutes_top_digit, an[3].
- Frame latch:
  - On the cycle where idx=3 and cnt wraps, all four inputs are registered into the latch; the new frame (idx=0) uses them.
  - Input changes at any other time are not displayed until the next frame.
  - The first frame after reset displays 0000.
- Outputs are registered, one cycle of latency from (idx, cnt, blink_phase, latch) to (an, seg, dp).
- Anode drive:
  - an = all ones while cnt < GUARD.
  - Otherwise an = ~(1<<idx), unless the slot is blanked.
- Blanking:
  - Minutes pair (idx 2,3) is blanked when is_minute_increasing=1 and blink_phase=0.
  - Seconds pair (idx 0,1) is blanked when is_second_increasing=1 and blink_phase=0.
  - Both flags high: all four digits blink in unison.
  - A blanked slot drives an=4'hF, seg=7'h7F, dp=1.
- Segment decode, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Codes 10–15 decode to 7'h7F (blank digit) and do not disturb the other slots.
- Decimal point: dp=0 only while idx=2 is driven (minutes:seconds separator); otherwise dp=1.
- Blink timing:
  - Blink counter runs 0..BLINK_DIV-1 free, independent of the scan.
  - blink_phase toggles at each wrap.
  - When both adjust flags are 0, blink_phase still runs but has no effect.
  - A flag rising mid-phase takes effect at the next output register update.

Test Plan:
- Params REFRESH_DIV=4, GUARD=1, BLINK_DIV=64. Hold rst=0 for 3 cycles → an=F, seg=7F, dp=1 every cycle; release → first frame shows digits 0.
- Inputs 1,2,3,4 (min_top..sec_bot), flags 0, run 2 frames → second frame:
  - an=E with seg=0011001;
  - an=D with seg=0110000;
  - an=B with seg=0100100 and dp=0;
  - an=7 with seg=1111001.
  - Each slot has exactly 1 guard cycle of an=F then 3 driven cycles.
- Change seconds_bot_digit 4→9 while idx=1 → remainder of the frame still shows 4; next frame idx 0 shows 0010000.
- is_minute_increasing=1, digits 5,9,5,9 → during blink_phase=0, slots 2,3 give an=F, seg=7F, dp=1 and slots 0,1 are unaffected; after 64 cycles, slots 2,3 reappear.
- seconds_top_digit=4'hC → slot 1 drives an=D with seg=7F; other slots decode normally.
- Assert rst=0 for 1 cycle mid-slot at idx=2 → next cycle outputs are at reset values; scanning resumes at idx 0 with a fresh guard period; blink_phase=1.
